// File: rtl/tug_playfield.sv
// -----------------------------------------------------------------------------
// tug_playfield
//
// Playfield for the tug-of-war game. The two level-sensitive player keys become
// single-cycle press pulses. A single lit LED moves one step toward the player
// who pressed, and it stops at either end without wrapping. The winner FSM
// raises temp at the end of a round, and the light then returns to the centre.
//
// Ports:
//   clk    - system clock; every state update happens on the rising edge
//   reset  - synchronous, active-high reset
//   key_l  - left player key, level, already synchronised to clk, 1 = pressed
//   key_r  - right player key, level, already synchronised to clk, 1 = pressed
//   temp   - round-over signal from the winner FSM, 1 = recentre
//   leds   - one-hot light position; leds[NUM_LIGHTS-1] is leftmost
//   L, R   - registered press pulses, one cycle per key press
//   loc1   - light is at the leftmost LED
//   loc2   - light is at the rightmost LED
//
// NUM_LIGHTS must be odd and at least 3 so that there is a unique centre LED.
// -----------------------------------------------------------------------------
module tug_playfield #(
    parameter int NUM_LIGHTS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_l,
    input  logic                  key_r,
    input  logic                  temp,
    output logic [NUM_LIGHTS-1:0] leds,
    output logic                  L,
    output logic                  R,
    output logic                  loc1,
    output logic                  loc2
);

    localparam int PW = $clog2(NUM_LIGHTS);

    localparam logic [PW-1:0] POS_CENTER = PW'(NUM_LIGHTS / 2);
    localparam logic [PW-1:0] POS_LEFT   = PW'(NUM_LIGHTS - 1);
    localparam logic [PW-1:0] POS_RIGHT  = '0;
    localparam logic [PW-1:0] POS_STEP   = PW'(1);

    logic [PW-1:0] pos_reg;
    logic          kl_reg;
    logic          kr_reg;
    logic          l_reg;
    logic          r_reg;
    logic [PW-1:0] pos_next;

    // Next position. It uses the pulses already registered, so the light moves
    // one edge after L/R appear. A recentre request overrides any movement in
    // the same cycle. Simultaneous presses cancel each other.
    always_comb begin
        pos_next = pos_reg;
        if (temp) begin
            pos_next = POS_CENTER;
        end else if (l_reg && !r_reg) begin
            if (pos_reg != POS_LEFT) begin
                pos_next = pos_reg + POS_STEP;
            end
        end else if (r_reg && !l_reg) begin
            if (pos_reg != POS_RIGHT) begin
                pos_next = pos_reg - POS_STEP;
            end
        end
    end

    // The previous key samples reset to 1. A key that is held through reset
    // therefore looks as if it was already pressed, and the player must release
    // it and press again to get a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_reg <= POS_CENTER;
            kl_reg  <= 1'b1;
            kr_reg  <= 1'b1;
            l_reg   <= 1'b0;
            r_reg   <= 1'b0;
        end else begin
            pos_reg <= pos_next;
            kl_reg  <= key_l;
            kr_reg  <= key_r;
            l_reg   <= key_l & ~kl_reg;
            r_reg   <= key_r & ~kr_reg;
        end
    end

    // One-hot decode of the position. Exactly one bit is set because pos_reg
    // never leaves the range 0..NUM_LIGHTS-1.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LIGHTS; gi = gi + 1) begin : g_led
            assign leds[gi] = (pos_reg == PW'(gi));
        end
    endgenerate

    assign L    = l_reg;
    assign R    = r_reg;
    assign loc1 = (pos_reg == POS_LEFT);
    assign loc2 = (pos_reg == POS_RIGHT);

endmodule

// File: tb/tb_tug_playfield.sv
// -----------------------------------------------------------------------------
// tb_tug_playfield
//
// Self-checking bench for tug_playfield (NUM_LIGHTS = 9). The reference model
// keeps the light position as a plain integer. A press is counted when a key is
// seen high after being seen low. The position then moves by the difference
// between the left and right presses, clamped to the row, and temp or reset
// recentres it. Directed scenarios come first, followed by a randomised phase.
// -----------------------------------------------------------------------------
module tb_tug_playfield;

    localparam int N = 9;
    localparam int C = N / 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_l = 1'b0;
    logic         key_r = 1'b0;
    logic         temp = 1'b0;
    logic [N-1:0] leds;
    logic         L;
    logic         R;
    logic         loc1;
    logic         loc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state.
    int m_pos = C;
    int m_l = 0;
    int m_r = 0;
    int m_prev_l = 1;
    int m_prev_r = 1;

    tug_playfield #(.NUM_LIGHTS(N)) dut (
        .clk  (clk),
        .reset(reset),
        .key_l(key_l),
        .key_r(key_r),
        .temp (temp),
        .leds (leds),
        .L    (L),
        .R    (R),
        .loc1 (loc1),
        .loc2 (loc2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge. The task applies the inputs, advances the model over the
    // same edge, and then compares all outputs 1 ns after the edge.
    task automatic step(input logic kl, input logic kr, input logic t, input logic rst);
        int new_l;
        int new_r;
        key_l = kl;
        key_r = kr;
        temp  = t;
        reset = rst;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_pos = C;
            m_l = 0;
            m_r = 0;
            m_prev_l = 1;
            m_prev_r = 1;
        end else begin
            new_l = (kl && !m_prev_l) ? 1 : 0;
            new_r = (kr && !m_prev_r) ? 1 : 0;
            if (t) begin
                m_pos = C;
            end else begin
                m_pos = m_pos + m_l - m_r;
                if (m_pos > N - 1) m_pos = N - 1;
                if (m_pos < 0) m_pos = 0;
            end
            m_l = new_l;
            m_r = new_r;
            m_prev_l = kl;
            m_prev_r = kr;
        end
        #1;
        $display("cyc %0d rst=%0b kl=%0b kr=%0b temp=%0b -> leds=%b L=%0b R=%0b loc1=%0b loc2=%0b",
                 cyc, rst, kl, kr, t, leds, L, R, loc1, loc2);
        check("leds", 32'(leds), 32'(1) << m_pos);
        check("L", 32'(L), 32'(m_l));
        check("R", 32'(R), 32'(m_r));
        check("loc1", 32'(loc1), (m_pos == N - 1) ? 32'd1 : 32'd0);
        check("loc2", 32'(loc2), (m_pos == 0) ? 32'd1 : 32'd0);
        check("onehot", 32'($countones(leds)), 32'd1);
    endtask

    task automatic press_l();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_r();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic kl_v;
        logic kr_v;
        logic t_v;
        logic rst_v;

        // Reset, then key_l held through the reset release.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_leds", 32'(leds), 32'b000010000);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("held_no_move", 32'(leds), 32'b000010000);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // A single press held for 5 cycles moves the light one step.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("one_step", 32'(leds), 32'b000100000);

        // Move to the left end, press again at the end, then recentre.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) press_l();
        check("left_end", 32'(leds), 32'b100000000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("end_pulse_loc1", 32'({L, loc1}), 32'b11);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("recentred", 32'(leds), 32'b000010000);

        // Five right presses: the light clamps at the rightmost LED.
        for (int i = 0; i < 5; i++) press_r();
        check("right_end", 32'(leds), 32'b000000001);

        // Simultaneous presses cancel; temp coincident with an L pulse.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("cancel", 32'(leds), 32'b000010000);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("temp_keeps_pulse", 32'(leds), 32'b000010000);

        // Move to pos 7 and reset while key_l is held.
        for (int i = 0; i < 3; i++) press_l();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_reset", 32'({leds, L}), {22'd0, 9'b000010000, 1'b0});
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        press_l();

        // Randomised phase.
        kl_v = 1'b0;
        kr_v = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) kl_v = ~kl_v;
            if ($urandom_range(0, 2) == 0) kr_v = ~kr_v;
            t_v   = ($urandom_range(0, 39) == 0);
            rst_v = ($urandom_range(0, 99) == 0);
            step(kl_v, kr_v, t_v, rst_v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_playfield.md
Name: tug_playfield

Overview:
- Playfield for the tug-of-war game. It turns two level-sensitive player keys into single-cycle press pulses.
- It tracks a single lit position on a row of NUM_LIGHTS LEDs and moves the light one step per press.
- It drives the press pulses (L, R) and edge-position flags (loc1, loc2) consumed by the winner FSM.
- It recentres the light when the winner FSM raises its round-over signal (temp).

Parameters:
NUM_LIGHTS, 9, number of LEDs in the playfield; odd, >= 3; leds[NUM_LIGHTS-1] is leftmost, leds[0] is rightmost.
CENTER, NUM_LIGHTS/2 (= 4), index of the centre LED; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
key_l  input  1  left player key, level, already synchronised to clk, 1 = pressed.
key_r  input  1  right player key, level, already synchronised to clk, 1 = pressed.
temp  input  1  round-over pulse from the winner FSM; 1 = recentre.
leds  output  NUM_LIGHTS  one-hot light position; drives LEDR[9:1] for NUM_LIGHTS=9.
L  output  1  left press pulse, exactly one cycle per key_l press.
R  output  1  right press pulse, exactly one cycle per key_r press.
loc1  output  1  1 when the light is at leftmost, leds[NUM_LIGHTS-1].
loc2  output  1  1 when the light is at rightmost, leds[0].

Behaviour:
- State:
  - pos: position index, width $clog2(NUM_LIGHTS).
  - kl_q, kr_q: previous key samples.
  - L, R: registered pulse outputs.
- Reset (reset=1 at posedge):
  - pos <= CENTER; L <= 0; R <= 0; kl_q <= 1; kr_q <= 1.
  - Result: leds = one-hot at CENTER (9'b000010000), loc1 = loc2 = 0.
  - Keys held through reset produce no pulse; a fresh release/press is required.
- Edge detection, every non-reset posedge:
  - kl_q <= key_l; L <= key_l & ~kl_q. R is the same with key_r / kr_q.
  - Latency: key_l first sampled high at edge n -> L = 1 during cycle n+1 only, regardless of hold length.
  - Releasing and re-pressing yields a new pulse.
  - A key high for a single cycle still yields one pulse.
- Movement, evaluated at a non-reset posedge using the current L, R, temp. Priority: reset > temp > movement.
  - temp=1: pos <= CENTER. Any L/R in that cycle is ignored for movement.
  - L=1, R=0: pos <= pos+1 if pos < NUM_LIGHTS-1, else hold (no wrap).
  - R=1, L=0: pos <= pos-1 if pos > 0, else hold (no wrap).
  - L=1, R=1: simultaneous presses cancel; pos holds.
  - Both 0: hold.
- Outputs:
  - leds = 1 << pos (combinational decode).
  - loc1 = (pos == NUM_LIGHTS-1); loc2 = (pos == 0).
  - Only one bit of leds may ever be 1, and never zero bits.
- Interaction with the winner FSM:
  - A press while already at an end produces L/R with loc1/loc2 = 1 in the same cycle. The winner registers the win from that.
  - The winner's temp arrives combinationally in that cycle; pos returns to CENTER at the next edge.
  - The edge pulses themselves are never suppressed by temp.
- Reset mid-game: any position returns to CENTER on the next edge; pending pulses are cleared.

Test Plan:
1. Reset 2 cycles, keys 0 -> leds=9'b000010000, L=R=loc1=loc2=0. Then hold key_l=1 through reset deassert -> no L pulse and leds unchanged.
2. From centre, key_l 0->1 held 5 cycles -> L high exactly 1 cycle, one edge after key sampled high. leds becomes 9'b000100000 on the following edge, then holds.
3. Four separate key_l presses from centre -> leds=9'b100000000, loc1=1. A fifth press -> L pulse with loc1=1, pos holds (no wrap). Then drive temp=1 for 1 cycle -> leds=9'b000010000 next edge.
4. Five separate key_r presses from centre -> leds=9'b000000001, loc2=1 after the 4th. The 5th holds at 0 and R pulses with loc2=1.
5. key_l and key_r rise on the same cycle -> L=R=1 same cycle, leds unchanged. temp=1 coincident with an L pulse -> pos=CENTER, L still pulses.
6. Move to pos=7, assert reset for 1 cycle mid-press (key_l high) -> leds=9'b000010000, L=0. After reset deasserts, the held key_l produces no pulse until re-pressed.
